rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Round-robin arbiter with grant locking that shares one resource among N requesters.
- A winner keeps the grant until it signals done, drops its request, or exceeds a hold limit.
- One idle turnaround cycle separates consecutive grants.
- Sits in front of a shared output or bus path and replaces per-cycle fixed-priority selection where fairness and ownership are needed.

Parameters:
- N, 4, number of requesters (2..16)
- MAX_HOLD, 16, max cycles a grant may be held before forced release (1..255)
- IDW, $clog2(N), width of gnt_id

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  N  per-requester request level; bit i = requester i
- done  input  N  per-requester release pulse; only the owner's bit is honoured
- gnt  output  N  one-hot grant, registered; all zero when no owner
- gnt_valid  output  1  high when gnt is non-zero
- gnt_id  output  IDW  index of current owner; 0 when gnt_valid is low
- timeout  output  1  one-cycle pulse in the cycle the grant is forced off by MAX_HOLD

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk and rst_n; rst_n is sampled only on the rising edge of clk.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- States:
  - IDLE (no owner, arbitrating)
  - OWN (grant held)
  - TURN (one-cycle turnaround, gnt=0, no arbitration)
- IDLE:
  - If req==0 at an edge, stay IDLE.
  - Otherwise, at that edge, pick the first set req bit scanning upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
  - Set gnt to one-hot of the winner, set gnt_id, clear hold_cnt, go to OWN.
  - Grant latency is 1 cycle from req being sampled high.
- OWN:
  - hold_cnt increments each cycle, saturating at MAX_HOLD.
  - Release when, at an edge, any of the following holds: done[owner]=1, req[owner]=0, or hold_cnt==MAX_HOLD-1.
  - The grant is therefore visible for at most MAX_HOLD cycles.
- On release at that edge:
  - gnt=0, gnt_id=0.
  - rr_ptr = (owner+1) mod N.
  - Go to TURN.
  - timeout=1 for that next cycle only if the release was caused solely by the hold limit. If done or a req drop coincides with the hold limit, timeout=0.
- TURN: gnt stays 0 for exactly one cycle, then go to IDLE and arbitrate normally. Minimum back-to-back spacing is grant, 1 gap, grant.
- Non-owner done bits: ignored in all states. done in IDLE or TURN: ignored.
- Requests: may change at any time. Only the owner's req bit affects OWN.
- Simultaneous requests: the rotation guarantees that every requester holding req high is granted within N grants.
- N=1: the lone requester is re-granted after each TURN.
- Reset mid-grant: on an edge with rst_n=0, all outputs drop to reset values in the following cycle regardless of state. rr_ptr returns to 0.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id matches gnt.

Optional Feature:
- Macro: RR_LOCK_ARB_PRIO0_EN
- Defined: requester 0 is urgent.
  - In IDLE, if req[0]=1 it wins regardless of rr_ptr.
  - A grant to requester 0 does not advance rr_ptr; it is left unchanged on release.
  - Hold limit and TURN still apply to requester 0.
- Undefined: pure round-robin as above; requester 0 has no special treatment.

Test Plan:
- Reset with req=4'b1111 held: gnt=0 during reset. One cycle after rst_n goes high, gnt=0001. Releasing via done each time gives grants 0001, 0010, 0100, 1000, 0001, each separated by one gnt=0 cycle.
- Hold limit, MAX_HOLD=4, req=0100 held, done=0: gnt=0100 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=0100 again.
- Request drop: owner 1 deasserts req[1] mid-grant. At the next edge gnt=0 and timeout=0; rr_ptr=2, so with req=1011 pending the next grant is 1000.
- Non-owner done: owner 2, pulse done=0001. gnt stays 0100 and hold_cnt is unaffected.
- Reset mid-grant: rst_n=0 for 1 cycle while gnt=1000. Next cycle gnt=0, gnt_id=0. After reset, with req=1001, the grant is 0001 (rr_ptr=0).
- With RR_LOCK_ARB_PRIO0_EN, rr_ptr=2 and req=0101: the grant goes to 0001. After release the next grant is 0100, since rr_ptr stays 2. Without the macro, the same stimulus grants 0100 first.

Source files
------------

// File: rtl/rr_lock_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_lock_arbiter_if
// Request/grant bundle between N requesters and the rr_lock_arbiter.
//
// Handshake: req[i] is a level held by requester i for as long as it wants
// the resource; gnt is a registered one-hot owner vector. The owner keeps
// the resource while gnt[i] is high and gives it back by pulsing done[i] or
// by dropping req[i]. The arbiter may also take it back on its own (timeout
// pulses in the cycle after such a forced release). There is no back-pressure
// on gnt: requesters must observe it every cycle.
//
// Signals:
//   req       N    requester -> arbiter  request levels
//   done      N    requester -> arbiter  release pulses (owner bit only)
//   gnt       N    arbiter -> requester  one-hot grant, zero when no owner
//   gnt_valid 1    arbiter -> requester  |gnt
//   gnt_id    IDW  arbiter -> requester  owner index, 0 when no owner
//   timeout   1    arbiter -> requester  forced-release pulse
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_lock_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;

  modport master (
    output req, done,
    input  gnt, gnt_valid, gnt_id, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, gnt_id, timeout
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// rr_lock_arbiter
// Round-robin arbiter with grant locking. A winner keeps the resource until
// it pulses done, drops its request, or has held it for MAX_HOLD cycles.
// Every release is followed by exactly one turnaround cycle with gnt=0.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   arb_if   slave modport of rr_lock_arbiter_if (req/done in, gnt/... out)
//   state_o  out  current FSM state (IDLE=0, OWN=1, TURN=2) for observation
//
// Optional build macro: RR_LOCK_ARB_PRIO0_EN
//   When defined, requester 0 wins any arbitration it takes part in, and a
//   grant to requester 0 leaves the rotation pointer untouched.
// ---------------------------------------------------------------------------
module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_lock_arbiter_if.slave   arb_if,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     hold_q, hold_d;
  logic           to_q, to_d;

  logic [IDW-1:0] win_id;
  logic [IDW-1:0] scan_idx;
  logic           found;
  logic           own_done, own_drop, hit_lim;

  // Rotating scan starting at ptr_q; first requester found wins.
  always_comb begin
    win_id   = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      scan_idx = IDW'((int'(ptr_q) + i) % N);
      if (!found && arb_if.req[scan_idx]) begin
        found  = 1'b1;
        win_id = scan_idx;
      end
    end
`ifdef RR_LOCK_ARB_PRIO0_EN
    if (arb_if.req[0]) win_id = '0;
`endif
  end

  assign own_done = arb_if.done[id_q];
  assign own_drop = !arb_if.req[id_q];
  assign hit_lim  = (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    case (state_q)
      // TURN is the gnt=0 gap cycle itself; the edge that ends it is where
      // arbitration lands, so back-to-back spacing is grant, 1 gap, grant.
      IDLE, TURN: begin
        state_d = IDLE;
        if (|arb_if.req) begin
          state_d        = OWN;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          id_d           = win_id;
          hold_d         = '0;
        end
      end
      OWN: begin
        if (own_done || own_drop || hit_lim) begin
          state_d = TURN;
          gnt_d   = '0;
          id_d    = '0;
          hold_d  = '0;
          // Timeout is only reported when the limit alone forced the release.
          to_d    = hit_lim && !own_done && !own_drop;
          ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
`ifdef RR_LOCK_ARB_PRIO0_EN
          if (id_q == '0) ptr_d = ptr_q;
`endif
        end else if (hold_q != 8'(MAX_HOLD)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign arb_if.gnt       = gnt_q;
  assign arb_if.gnt_valid = |gnt_q;
  assign arb_if.gnt_id    = id_q;
  assign arb_if.timeout   = to_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_lock_arbiter
// Directed bench for rr_lock_arbiter with N=4, MAX_HOLD=4. Each step drives
// rst_n/req/done, pushes the expected outputs for the following edge onto
// exp_q, then pops and compares them one time unit after that edge.
// Expected record layout: {timeout, gnt_valid, gnt_id[1:0], gnt[3:0]}.
// ---------------------------------------------------------------------------
module tb_rr_lock_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int W        = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;

  rr_lock_arbiter_if #(.N(N)) bus ();

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_if  (bus.slave),
    .state_o (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] pack_exp(input logic [3:0] g, input logic to);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < N; i++) if (g[i]) id = 2'(i);
    return {to, |g, id, g};
  endfunction

  // Driver task: one clock step with a check of the outputs it produces.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                      input logic [3:0] eg, input logic et, input string tag);
    logic [W-1:0] obs, exp;
    rst_n    = r;
    bus.req  = rq;
    bus.done = dn;
    exp_q.push_back(pack_exp(eg, et));
    @(posedge clk);
    #1;
    obs = {bus.timeout, bus.gnt_valid, bus.gnt_id, bus.gnt};
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef RR_LOCK_ARB_PRIO0_EN
  logic [3:0] p1_seq [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
  localparam logic [3:0] DROP_NEXT = 4'b0001;
  localparam logic [3:0] PRIO_FIRST = 4'b0001;
`else
  logic [3:0] p1_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  localparam logic [3:0] DROP_NEXT = 4'b1000;
  localparam logic [3:0] PRIO_FIRST = 4'b0100;
`endif

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;

    // Reset held with all requesters asking
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, "reset_a");
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, "reset_b");
    vectors++;
    assert (state_o === 2'd0) else begin
      miscompares++;
      $error("FAIL reset_state: observed %0d expected 0", state_o);
    end

    // Rotation, each owner releasing via done
    step(1'b1, 4'b1111, 4'b0000, p1_seq[0], 1'b0, "rot_first");
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'b1111, p1_seq[k], 4'b0000, 1'b0, "rot_gap");
      step(1'b1, 4'b1111, 4'b0000, p1_seq[k+1], 1'b0, "rot_grant");
    end

    // Hold limit: owner 2 keeps requesting, never signals done
    step(1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, "hold_drop0");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "hold_c0");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "hold_c1");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "hold_c2");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "hold_c3");
    step(1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, "hold_timeout");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "hold_regrant");

    // Non-owner done must neither release nor reset the hold count
    step(1'b1, 4'b0100, 4'b0001, 4'b0100, 1'b0, "nonown_done");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "nonown_c2");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "nonown_c3");
    step(1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, "nonown_timeout");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle_norq");

    // Request drop by owner 1, then pending 1011 from rr_ptr=2
    step(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, "drop_grant");
    step(1'b1, 4'b1011, 4'b0000, 4'b0010, 1'b0, "drop_hold");
    step(1'b1, 4'b1001, 4'b0000, 4'b0000, 1'b0, "drop_release");
    step(1'b1, 4'b1011, 4'b0000, DROP_NEXT, 1'b0, "drop_next");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "drop_release2");
    step(1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0, "owner3");

    // Reset mid-grant
    step(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, "midrst");
    step(1'b1, 4'b1001, 4'b0000, 4'b0001, 1'b0, "postrst_grant");
    step(1'b1, 4'b1001, 4'b0001, 4'b0000, 1'b0, "postrst_rel");

    // Bring rr_ptr to 2, then contend requesters 0 and 2
    step(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, "ptr_grant1");
    step(1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b0, "ptr_rel1");
    step(1'b1, 4'b0101, 4'b0000, PRIO_FIRST, 1'b0, "prio_first");
    step(1'b1, 4'b0101, PRIO_FIRST, 4'b0000, 1'b0, "prio_rel");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "prio_second");

    // done coinciding with the hold limit must not report timeout
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "coin_c1");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "coin_c2");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, "coin_c3");
    step(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, "coin_release");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "final_idle");

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL exp_q_drain: observed %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
